// File: rtl/ds_pkg.sv
`default_nettype none
// ============================================================================
// ds_pkg : shared constants for the delta-sigma interpolating modulator and
//          the matching decimation chain (output codes, LFSR, width helper).
// Rev 1.0
// ============================================================================
package ds_pkg;

  localparam int unsigned DS_IN_W = 22;

  typedef enum logic [1:0] {
    DS_CODE_IDLE = 2'b00,
    DS_CODE_POS  = 2'b01,
    DS_CODE_NEG  = 2'b11
  } ds_code_e;

  // Fibonacci taps for x^16 + x^14 + x^13 + x^11 + 1 (bits 15, 13, 12, 10)
  localparam logic [15:0] DS_LFSR_TAPS = 16'hB400;
  localparam logic [15:0] DS_LFSR_SEED = 16'hACE1;

  function automatic int cic_int_width(input int in_w, input int n, input int r);
    return in_w + (n - 1) * $clog2(r);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cic_interp.sv
`default_nettype none
// ============================================================================
// cic_interp : phase counter, N-stage comb section, zero-stuffing and
//              N-stage wrap-around integrator section of a CIC interpolator.
// Rev 1.0
// ============================================================================
module cic_interp
  import ds_pkg::*;
#(
  parameter int IN_W = DS_IN_W,
  parameter int R    = 64,
  parameter int N    = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ce_i,
  input  logic                   load_i,
  input  logic signed [IN_W-1:0] x_i,
  output logic                   wrap_o,
  output logic signed [IN_W-1:0] u_o
);

  localparam int PW = $clog2(R);
  localparam int CW = IN_W + N;
  localparam int IW = cic_int_width(IN_W, N, R);
  localparam int SH = (N - 1) * PW;

  logic        [PW-1:0] ph_q;
  logic signed [CW-1:0] dly_q   [N];
  logic signed [CW-1:0] comb_in [N];
  logic signed [CW-1:0] comb_out;
  logic signed [CW-1:0] acc;
  logic signed [CW-1:0] comb_q;
  logic                 stuff_q;
  logic signed [IW-1:0] integ_q [N];

  always_comb begin
    acc = CW'(x_i);
    for (int k = 0; k < N; k++) begin
      comb_in[k] = acc;
      acc        = acc - dly_q[k];
    end
    comb_out = acc;
  end

  // comb_q is fed to the first integrator for exactly one tick after a load
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ph_q    <= '0;
      comb_q  <= '0;
      stuff_q <= 1'b0;
      for (int k = 0; k < N; k++) begin
        dly_q[k]   <= '0;
        integ_q[k] <= '0;
      end
    end else if (ce_i) begin
      ph_q    <= ph_q + PW'(1);
      stuff_q <= load_i;
      if (load_i) begin
        comb_q <= comb_out;
        for (int k = 0; k < N; k++) begin
          dly_q[k] <= comb_in[k];
        end
      end
      integ_q[0] <= integ_q[0] + (stuff_q ? IW'(comb_q) : '0);
      for (int k = 1; k < N; k++) begin
        integ_q[k] <= integ_q[k] + integ_q[k-1];
      end
    end
  end

  assign wrap_o = (ph_q == PW'(R - 1));
  assign u_o    = IN_W'(integ_q[N-1] >>> SH);

endmodule
`default_nettype wire

// File: rtl/ds_interp_modulator.sv
`default_nettype none
// ============================================================================
// ds_interp_modulator : CIC interpolator followed by a 2nd-order CIFB
//                       delta-sigma modulator producing a 2-bit code stream.
// Optional LFSR dither on the quantizer input: define DSM_DITHER_EN.
// Rev 1.0
// ============================================================================
module ds_interp_modulator
  import ds_pkg::*;
#(
  parameter int IN_W = DS_IN_W,
  parameter int R    = 64,
  parameter int N    = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clk_enable,
  input  logic signed [IN_W-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [1:0]             filter_out,
  output logic                   ce_out,
  output logic                   underrun
);

  localparam int MW = IN_W + 4;
  localparam int WW = IN_W + 6;

  localparam logic signed [IN_W-1:0] CLAMP_HI = {2'b01, {(IN_W-2){1'b0}}};
  localparam logic signed [IN_W-1:0] CLAMP_LO = {2'b11, {(IN_W-2){1'b0}}};
  localparam logic signed [WW-1:0]   FS_W     = {{(WW-IN_W){1'b0}}, 1'b1, {(IN_W-1){1'b0}}};
  localparam logic signed [WW-1:0]   SAT_MAX  = {{(WW-MW+1){1'b0}}, {(MW-1){1'b1}}};
  localparam logic signed [WW-1:0]   SAT_MIN  = {{(WW-MW+1){1'b1}}, {(MW-1){1'b0}}};

  logic                   wrap;
  logic signed [IN_W-1:0] x_clamped;
  logic signed [IN_W-1:0] u;
  logic signed [MW-1:0]   s1_q, s1_d, s2_q, s2_d;
  logic signed [WW-1:0]   q_in, y_fs;
  logic                   y_pos;
  logic [1:0]             filter_out_q;
  logic                   ce_out_q;
  logic                   underrun_q;

  function automatic logic signed [MW-1:0] sat(input logic signed [WW-1:0] v);
    if (v > SAT_MAX)      return SAT_MAX[MW-1:0];
    else if (v < SAT_MIN) return SAT_MIN[MW-1:0];
    else                  return v[MW-1:0];
  endfunction

  assign in_ready = clk_enable & wrap;

  // A missing sample at the wrap is replaced by zero
  always_comb begin
    x_clamped = '0;
    if (in_valid) begin
      if (in_data > CLAMP_HI)      x_clamped = CLAMP_HI;
      else if (in_data < CLAMP_LO) x_clamped = CLAMP_LO;
      else                         x_clamped = in_data;
    end
  end

  cic_interp #(
    .IN_W (IN_W),
    .R    (R),
    .N    (N)
  ) u_cic (
    .clk    (clk),
    .reset  (reset),
    .ce_i   (clk_enable),
    .load_i (in_ready),
    .x_i    (x_clamped),
    .wrap_o (wrap),
    .u_o    (u)
  );

`ifdef DSM_DITHER_EN
  localparam logic signed [WW-1:0] ONE_W = WW'(1);
  logic [15:0] lfsr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_q <= DS_LFSR_SEED;
    end else if (clk_enable) begin
      lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & DS_LFSR_TAPS)};
    end
  end

  assign q_in = WW'(s2_q) + (lfsr_q[0] ? ONE_W : -ONE_W);
`else
  assign q_in = WW'(s2_q);
`endif

  // s2 integrates the freshly updated s1, giving NTF = (1 - z^-1)^2
  always_comb begin
    y_pos = ~q_in[WW-1];
    y_fs  = y_pos ? FS_W : -FS_W;
    s1_d  = sat(WW'(s1_q) + WW'(u) - y_fs);
    s2_d  = sat(WW'(s2_q) + WW'(s1_d) - y_fs);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q         <= '0;
      s2_q         <= '0;
      filter_out_q <= DS_CODE_IDLE;
      ce_out_q     <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      ce_out_q <= clk_enable;
      if (clk_enable) begin
        s1_q         <= s1_d;
        s2_q         <= s2_d;
        filter_out_q <= y_pos ? DS_CODE_POS : DS_CODE_NEG;
        if (wrap && !in_valid) underrun_q <= 1'b1;
      end
    end
  end

  assign filter_out = filter_out_q;
  assign ce_out     = ce_out_q;
  assign underrun   = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_ds_interp_modulator.sv
`default_nettype none
// ============================================================================
// tb_ds_interp_modulator : directed self-checking bench for ds_interp_modulator.
// Rev 1.0
// ============================================================================
module tb_ds_interp_modulator;

  localparam int IN_W = 22;
  localparam int R    = 64;
  localparam int N    = 3;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   clk_enable;
  logic signed [IN_W-1:0] in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic [1:0]             filter_out;
  logic                   ce_out;
  logic                   underrun;

  int n_tests = 0;
  int n_fail  = 0;

  ds_interp_modulator #(.IN_W(IN_W), .R(R), .N(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .filter_out (filter_out),
    .ce_out     (ce_out),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int val, input int lo, input int hi);
    n_tests++;
    assert (val >= lo && val <= hi) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, val, lo, hi);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic density(input int settle, output int ones);
    repeat (settle) step();
    ones = 0;
    repeat (1024) begin
      step();
      if (filter_out == 2'b01) ones++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] pat [4];
    int first_rdy, n, ones, a, b, ce_err, hold_err, rdy_err;
    logic en;
    logic [1:0] fo;

    pat = '{2'b01, 2'b11, 2'b11, 2'b01};
    reset = 1'b0; clk_enable = 1'b1; in_valid = 1'b0; in_data = '0;

    // Reset state, with clk_enable high so in_ready gating on ph is exercised
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_filter_out", filter_out, 2'b00);
    chk("rst_ce_out", ce_out, 0);
    chk("rst_underrun", underrun, 0);

    // Zero input: modulator runs the 4-periodic cycle +1,-1,-1,+1
    reset = 1'b1; in_valid = 1'b1;
    first_rdy = 0;
    for (int t = 1; t <= R + 8; t++) begin
      if (in_ready && first_rdy == 0) first_rdy = t;
      step();
      if (t <= 8) chk($sformatf("zero_pat_%0d", t), filter_out, pat[(t-1)%4]);
    end
    chk("first_ready_tick", first_rdy, R);
    chk("ce_out_enabled", ce_out, 1);

    n = 0;
    while (!in_ready && n < 4 * R) begin step(); n++; end
    step();
    n = 1;
    while (!in_ready && n < 4 * R) begin step(); n++; end
    chk("ready_period", n, R);

    density(256, ones);
    chk_rng("dens_zero", ones, 510, 514);

    in_data = 22'sd524288;
    density(2048, ones);
    chk_rng("dens_pos_quarter", ones, 636, 644);

    in_data = -22'sd524288;
    density(2048, ones);
    chk_rng("dens_neg_quarter", ones, 380, 388);

    in_data = 22'sd2097151;
    density(2048, ones);
    chk_rng("dens_full_clamped", ones, 764, 772);
    chk("underrun_stays_low", underrun, 0);

    // Underrun: drop in_valid across one wrap
    in_valid = 1'b0;
    n = 0;
    while (!in_ready && n < 2 * R) begin step(); n++; end
    chk("underrun_wrap_found", in_ready, 1);
    chk("underrun_pre", underrun, 0);
    step();
    chk("underrun_set", underrun, 1);
    in_valid = 1'b1;
    repeat (3 * R) step();
    chk("underrun_sticky", underrun, 1);
    chk("no_x_output", $isunknown(filter_out), 0);

    // clk_enable at 1-in-3 duty
    a = -1; b = -1; ce_err = 0; hold_err = 0; rdy_err = 0;
    for (int cyc = 0; cyc < 9 * R; cyc++) begin
      clk_enable = (cyc % 3 == 0);
      #1;
      if (in_ready && !clk_enable) rdy_err++;
      if (in_ready) begin
        if (a < 0) a = cyc;
        else if (b < 0) b = cyc;
      end
      en = clk_enable;
      fo = filter_out;
      @(posedge clk); #1;
      if (ce_out !== en) ce_err++;
      if (!en && filter_out !== fo) hold_err++;
    end
    chk("ce_out_mirror_errs", ce_err, 0);
    chk("hold_when_disabled_errs", hold_err, 0);
    chk("ready_gated_errs", rdy_err, 0);
    chk("ready_period_div3", b - a, 3 * R);
    clk_enable = 1'b1;
    step();

    // Asynchronous reset mid-cycle
    #2 reset = 1'b0;
    #1;
    chk("async_rst_filter_out", filter_out, 2'b00);
    chk("async_rst_ce_out", ce_out, 0);
    chk("async_rst_underrun", underrun, 0);
    chk("async_rst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    step();
    chk("post_rst_first_code", filter_out, 2'b01);
    chk("post_rst_ce_out", ce_out, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
